md_issue_unit: RTL and testbench
================================

# md_issue_unit

Pipeline-side initiator for the multiply/divide unit. It sits in the E stage between the decoded instruction stream and `MULT_DIV`. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo requests and drives `MULT_DIV`'s start/ctrl/mthi/mtlo/operand inputs with registered one-cycle pulses. It tracks the outstanding operation, returns HI/LO read data, and raises `stall` to freeze the pipeline on any structural hazard.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; also resets `MULT_DIV`
- `op_valid`  in  1  E-stage instruction is an MD-class op
- `op_code`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo
- `op_a`  in  32  rs value; mthi/mtlo write data
- `op_b`  in  32  rt value
- `op_cancel`  in  1  flush/exception on this instruction; the op must have no effect
- `md_busy`  in  1  from `MULT_DIV.busy`
- `md_hi`, `md_lo`  in  32  from `MULT_DIV.HI`/`LO`
- `md_start`  out  1  one-cycle start pulse
- `md_ctrl`  out  2  equals `op_code[1:0]` of the launched op
- `md_inA`, `md_inB`  out  32  latched operands
- `md_mthi`, `md_mtlo`  out  1  one-cycle write pulses
- `md_dataW`  out  32  latched `op_a` for mthi/mtlo
- `stall`  out  1  hold the E stage and upstream stages
- `rd_valid`  out  1  mfhi/mflo result valid this cycle
- `rd_data`  out  32  `md_hi` or `md_lo`
- `stall_cnt`  out  16  saturating count of stalled cycles

## Operation
- FSM states:
  - IDLE
  - LAUNCH: `md_start` high for one cycle.
  - WRITE: `md_mthi` or `md_mtlo` high for one cycle.
  - BUSY: waiting for `md_busy` low.
- Define `take = op_valid & ~op_cancel & ~stall`.
- Stall condition: `stall = op_valid & ~op_cancel & (state != IDLE | md_busy)`. Stall is combinational. mfhi/mflo stall under the same condition.
- IDLE with `take`:
  - codes 0–3: latch `md_inA`/`md_inB`/`md_ctrl`, go to LAUNCH.
  - codes 4/5: latch `md_dataW = op_a`, go to WRITE. Exactly one of `md_mthi`/`md_mtlo` is set, per code.
  - codes 6/7: state unchanged. `rd_valid = 1` and `rd_data` is `md_hi` (code 6) or `md_lo` (code 7), combinationally in the same cycle.
- LAUNCH: go to BUSY unconditionally.
- WRITE: go to IDLE unconditionally.
- BUSY: go to IDLE on the first edge where `md_busy == 0` is sampled. A unit that never raises busy costs exactly one BUSY cycle.
- `op_cancel` has priority over everything: no latch, no stall, `rd_valid = 0`. It does not abort an op already in LAUNCH, WRITE or BUSY.
- `md_start`, `md_mthi` and `md_mtlo` are never high together, and are never high outside their own state.
- `stall_cnt` increments each cycle `stall` is high and saturates at 0xFFFF.
- Reset: state IDLE, all outputs 0, operand and data latches 0, `stall_cnt` 0. Reset mid-LAUNCH or mid-BUSY abandons the op, and `MULT_DIV` is reset in the same edge.

## Timing
- Op taken at edge T; `md_start` (or `md_mthi`/`md_mtlo`) is high during cycle T..T+1. `MULT_DIV` samples it at edge T+1.
- After a mult/div, the next MD op is accepted no earlier than the edge after `md_busy` is first seen low. Minimum issue-to-issue spacing is 3 cycles (LAUNCH, BUSY, IDLE).
- An mfhi immediately after an mthi stalls exactly 1 cycle (WRITE). It returns the new value in the following cycle.
- Back-to-back mfhi/mflo in IDLE with `md_busy` low never stall.
- `stall` depends on the current-cycle `op_valid`/`op_cancel`. The pipeline re-presents a stalled op unchanged.

## Test plan
- Issue mult, A=-10, B=23 -> `md_start` pulse 1 cycle later with `md_ctrl = 00`. Stall holds until busy drops. A following mfhi/mflo returns 0xFFFFFFFF / 0xFFFFFF1A.
- Issue div, A=-32, B=-5, then mflo on the next cycle -> `stall` high through LAUNCH and BUSY. Then `rd_valid` with LO = 6, and HI = 0xFFFFFFFE on mfhi.
- Issue mthi with `op_a = 0xABCDEF00`, then mfhi -> one `md_mthi` pulse, 1 stall cycle, then `rd_data = 0xABCDEF00`. `stall_cnt` increments by 1.
- Issue divu with `op_cancel = 1` -> no `md_start`, no stall, state stays IDLE. HI/LO are unchanged on a later mfhi/mflo.
- Issue multu, assert `reset` during BUSY -> next cycle all outputs are 0 and the state is IDLE. An immediately following mflo returns 0 without stall.
- Hold `op_valid` with a stall for 70000 cycles -> `stall_cnt` saturates at 0xFFFF.

Source files
------------

// File: rtl/md_issue_if.sv
// Bundle between the E-stage issue unit, the pipeline and MULT_DIV.
//   op_*           : decoded MD request from the pipeline
//   md_busy/hi/lo  : status and result registers returned by MULT_DIV
//   md_start/ctrl/inA/inB/mthi/mtlo/dataW : launch and write controls to MULT_DIV
//   stall, rd_valid, rd_data, stall_cnt   : pipeline-facing results
// slave  : view used by md_issue_unit
// master : view used by the surrounding pipeline / MULT_DIV environment
interface md_issue_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_cancel;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_start;
  logic [1:0]  md_ctrl;
  logic [31:0] md_inA;
  logic [31:0] md_inB;
  logic        md_mthi;
  logic        md_mtlo;
  logic [31:0] md_dataW;
  logic        stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [15:0] stall_cnt;

  modport slave (
    input  op_valid, op_code, op_a, op_b, op_cancel, md_busy, md_hi, md_lo,
    output md_start, md_ctrl, md_inA, md_inB, md_mthi, md_mtlo, md_dataW,
           stall, rd_valid, rd_data, stall_cnt
  );

  modport master (
    output op_valid, op_code, op_a, op_b, op_cancel, md_busy, md_hi, md_lo,
    input  md_start, md_ctrl, md_inA, md_inB, md_mthi, md_mtlo, md_dataW,
           stall, rd_valid, rd_data, stall_cnt
  );
endinterface

// File: rtl/md_issue_unit.sv
// E-stage initiator for the multiply/divide unit.
// Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo, drives MULT_DIV with
// registered one-cycle start/mthi/mtlo pulses and latched operands, returns
// HI/LO read data, and stalls the pipeline while an op is outstanding.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (MULT_DIV is reset on the same edge)
//   bus   : md_issue_if.slave (pipeline request, MULT_DIV controls/status,
//           stall, read data, saturating stall counter)
module md_issue_unit (
  input  logic      clk,
  input  logic      reset,
  md_issue_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WRITE  = 2'd2,
    BUSY   = 2'd3
  } state_t;

  state_t        state;
  logic          start_q;
  logic          mthi_q;
  logic          mtlo_q;
  logic [1:0]    ctrl_q;
  logic [DW-1:0] ina_q;
  logic [DW-1:0] inb_q;
  logic [DW-1:0] dataw_q;
  logic [CW-1:0] stall_cnt_q;

  logic live_c;
  logic stall_c;
  logic take_c;
  logic rd_valid_c;

  // A cancelled op is invisible: it neither stalls nor is taken.
  assign live_c     = bus.op_valid & ~bus.op_cancel;
  assign stall_c    = live_c & ((state != IDLE) | bus.md_busy);
  assign take_c     = live_c & ~stall_c;
  // mfhi/mflo complete in the cycle they are taken; the FSM never leaves IDLE.
  assign rd_valid_c = take_c & (bus.op_code[2:1] == 2'b11);

  // Issue FSM, launch/write pulses, operand latches and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      mthi_q      <= 1'b0;
      mtlo_q      <= 1'b0;
      ctrl_q      <= '0;
      ina_q       <= '0;
      inb_q       <= '0;
      dataw_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      mthi_q  <= 1'b0;
      mtlo_q  <= 1'b0;
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CW'(1);
      end
      case (state)
        IDLE: begin
          if (take_c && !bus.op_code[2]) begin
            ctrl_q  <= bus.op_code[1:0];
            ina_q   <= bus.op_a;
            inb_q   <= bus.op_b;
            start_q <= 1'b1;
            state   <= LAUNCH;
          end else if (take_c && !bus.op_code[1]) begin
            dataw_q <= bus.op_a;
            mthi_q  <= ~bus.op_code[0];
            mtlo_q  <= bus.op_code[0];
            state   <= WRITE;
          end
        end
        LAUNCH:  state <= BUSY;
        WRITE:   state <= IDLE;
        // MULT_DIV raises busy on the LAUNCH->BUSY edge, so the first low
        // sample here already reflects the launched op.
        BUSY:    if (!bus.md_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.md_start  = start_q;
  assign bus.md_mthi   = mthi_q;
  assign bus.md_mtlo   = mtlo_q;
  assign bus.md_ctrl   = ctrl_q;
  assign bus.md_inA    = ina_q;
  assign bus.md_inB    = inb_q;
  assign bus.md_dataW  = dataw_q;
  assign bus.stall     = stall_c;
  assign bus.rd_valid  = rd_valid_c;
  // Read data is held at zero whenever no read completes.
  assign bus.rd_data   = !rd_valid_c ? '0 : (bus.op_code[0] ? bus.md_lo : bus.md_hi);
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_unit.sv
// Randomized, scoreboarded bench for md_issue_unit with a behavioural
// MULT_DIV model of configurable latency.
module tb_md_issue_unit;

  localparam int CLK_HALF     = 5;
  localparam int STALL_BUDGET = 70000;

  typedef struct packed {
    logic [1:0]  kind;   // 0 start, 1 mthi, 2 mtlo, 3 read
    logic [1:0]  ctrl;
    logic [31:0] x;
    logic [31:0] y;
  } ev_t;

  logic clk;
  logic reset;
  md_issue_if bus();

  md_issue_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #(CLK_HALF) clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  ev_t exp_q[$];
  int  lat_q[$];

  // Architectural HI/LO as the program sees them, plus timing bookkeeping.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          cost;       // stall cycles an op presented now should see
  int          stall_sum;  // expected stall_cnt (saturating)

  function automatic logic [63:0] md_calc(input logic [1:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    logic signed [31:0] qa, qb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qa = a;
    qb = b;
    r  = cur;
    case (ctrl)
      2'd0: r = 64'(sa * sb);
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: if (b != 0) begin
              if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, a};
              else r = {32'(qa % qb), 32'(qa / qb)};
            end
      default: if (b != 0) r = {a % b, a / b};
    endcase
    return r;
  endfunction

  // MULT_DIV model: result lands in HI/LO on the edge busy drops
  // (or on the start edge for a zero-latency op).
  int          md_cnt;
  logic [63:0] md_res;
  always @(posedge clk) begin
    if (reset) begin
      bus.md_busy <= 1'b0;
      bus.md_hi   <= '0;
      bus.md_lo   <= '0;
      md_cnt      <= 0;
    end else if (bus.md_start) begin
      int l;
      logic [63:0] r;
      l = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      r = md_calc(bus.md_ctrl, bus.md_inA, bus.md_inB, {bus.md_hi, bus.md_lo});
      if (l == 0) begin
        bus.md_hi <= r[63:32];
        bus.md_lo <= r[31:0];
      end else begin
        md_res      <= r;
        md_cnt      <= l;
        bus.md_busy <= 1'b1;
      end
    end else if (bus.md_busy) begin
      if (md_cnt == 1) begin
        bus.md_busy <= 1'b0;
        bus.md_hi   <= md_res[63:32];
        bus.md_lo   <= md_res[31:0];
      end
      md_cnt <= md_cnt - 1;
    end else begin
      if (bus.md_mthi) bus.md_hi <= bus.md_dataW;
      if (bus.md_mtlo) bus.md_lo <= bus.md_dataW;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every pulse or read result must match the oldest expected event.
  ev_t act_ev, exp_ev;
  always @(negedge clk) begin
    if (!reset && (bus.md_start || bus.md_mthi || bus.md_mtlo || bus.rd_valid)) begin
      if (bus.md_start)     act_ev = {2'd0, bus.md_ctrl, bus.md_inA, bus.md_inB};
      else if (bus.md_mthi) act_ev = {2'd1, 2'd0, bus.md_dataW, 32'd0};
      else if (bus.md_mtlo) act_ev = {2'd2, 2'd0, bus.md_dataW, 32'd0};
      else                  act_ev = {2'd3, 2'd0, bus.rd_data, 32'd0};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_event: got unexpected %h, want none", act_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev !== exp_ev) begin
          n_err++;
          $display("FAIL sb_event: got %h, want %h", act_ev, exp_ev);
        end
      end
    end
  end

  // One non-issuing cycle; optionally a cancelled op that must be ignored.
  task automatic idle_cycle(input bit cxl, input logic [2:0] code,
                            input logic [31:0] a, input logic [31:0] b);
    bus.op_valid  = cxl;
    bus.op_cancel = cxl;
    bus.op_code   = code;
    bus.op_a      = a;
    bus.op_b      = b;
    @(negedge clk);
    if (cxl) begin
      chk("cancel_stall", 64'(bus.stall), 64'd0);
      chk("cancel_rd_valid", 64'(bus.rd_valid), 64'd0);
    end
    @(posedge clk); #1;
    bus.op_valid  = 1'b0;
    bus.op_cancel = 1'b0;
    if (cost > 0) cost--;
  endtask

  // Present an op and hold it until accepted; checks stall length and counter.
  task automatic issue(input logic [2:0] code, input logic [31:0] a,
                       input logic [31:0] b, input int lat);
    int exp_stall, stalls;
    logic [63:0] r;
    exp_stall = cost;
    case (code)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        lat_q.push_back(lat);
        r = md_calc(code[1:0], a, b, {m_hi, m_lo});
        m_hi = r[63:32];
        m_lo = r[31:0];
        exp_q.push_back({2'd0, code[1:0], a, b});
      end
      3'd4: begin m_hi = a; exp_q.push_back({2'd1, 2'd0, a, 32'd0}); end
      3'd5: begin m_lo = a; exp_q.push_back({2'd2, 2'd0, a, 32'd0}); end
      3'd6: exp_q.push_back({2'd3, 2'd0, m_hi, 32'd0});
      default: exp_q.push_back({2'd3, 2'd0, m_lo, 32'd0});
    endcase
    bus.op_valid  = 1'b1;
    bus.op_cancel = 1'b0;
    bus.op_code   = code;
    bus.op_a      = a;
    bus.op_b      = b;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
      if (stalls > STALL_BUDGET) begin
        n_cmp++;
        n_err++;
        $display("FAIL stall_timeout: got %0d stalled cycles, want %0d", stalls, exp_stall);
        break;
      end
      @(posedge clk); #1;
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_stall));
    stall_sum = (stall_sum + exp_stall > 65535) ? 65535 : stall_sum + exp_stall;
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(stall_sum));
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op_code  = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    if (code < 3'd6)
      chk("pulse_after_take", 64'({bus.md_start, bus.md_mthi, bus.md_mtlo}),
          64'({code < 3'd4, code == 3'd4, code == 3'd5}));
    cost = (code < 3'd4) ? lat + 2 : (code < 3'd6) ? 1 : 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, 64'({bus.md_start, bus.md_mthi, bus.md_mtlo, bus.md_ctrl}), 64'd0);
    chk({tag, "_inA_inB"}, {bus.md_inA, bus.md_inB}, 64'd0);
    chk({tag, "_dataW"}, 64'(bus.md_dataW), 64'd0);
    chk({tag, "_status"}, 64'({bus.stall, bus.rd_valid, bus.rd_data, bus.stall_cnt}), 64'd0);
  endtask

  initial begin
    #(CLK_HALF * 2 * 95000);
    $display("FAIL watchdog: simulation still running after 95000 cycles, want finish");
    $fatal(1);
  end

  logic [2:0]  code;
  logic [31:0] ra, rb;
  int          gap;

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_cancel = 1'b0;
    bus.op_code   = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    m_hi = '0; m_lo = '0; cost = 0; stall_sum = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;

    // mult -10 * 23, then read both halves
    issue(3'd0, 32'hFFFF_FFF6, 32'd23, 4);
    issue(3'd6, '0, '0, 0);
    issue(3'd7, '0, '0, 0);
    chk("mult_hi_lo", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FF1A);

    // div -32 / -5, mflo immediately
    issue(3'd2, 32'hFFFF_FFE0, 32'hFFFF_FFFB, 7);
    issue(3'd7, '0, '0, 0);
    issue(3'd6, '0, '0, 0);

    // mthi then mfhi: one write cycle of stall
    issue(3'd4, 32'hABCD_EF00, '0, 0);
    issue(3'd6, '0, '0, 0);

    // cancelled divu is ignored; HI/LO unchanged
    idle_cycle(1'b1, 3'd3, 32'd100, 32'd7);
    issue(3'd6, '0, '0, 0);
    issue(3'd7, '0, '0, 0);

    // randomized mix of ops, gaps, cancels and latencies
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        idle_cycle($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      code = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 200)) - 32'd100;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20)) - 32'd10;
      if (code[2:1] == 2'b01 && rb == 32'd0) rb = 32'd1;
      if (code == 3'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      issue(code, ra, rb, $urandom_range(0, 6));
    end

    // multu, then reset while MULT_DIV is busy
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 20);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lat_q.delete();
    m_hi = '0; m_lo = '0; cost = 0; stall_sum = 0;
    @(negedge clk);
    chk_all_zero("mid_busy_reset");
    @(posedge clk); #1;
    issue(3'd7, '0, '0, 0);

    // long stall saturates the counter
    issue(3'd0, 32'd3, 32'd5, 66000);
    issue(3'd6, '0, '0, 0);
    issue(3'd7, '0, '0, 0);

    repeat (4) idle_cycle(1'b0, '0, '0, '0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
